haar_addr_gen: RTL

Parametrised integral-image address generator for Haar-feature evaluation. Accepts one feature descriptor per handshake: up to MAX_RECT rectangles, a signed weight per rectangle, and a scan-window base address. Emits the four corner addresses of each rectangle into the integral-image RAM read port as a valid/ready stream, tagged with corner sign, weight and position. It sits between the feature/cascade memory reader and the single-read-port integral-image RAM, and replaces the fixed 3-rectangle, wait-flag style parser with explicit backpressure.

---
 rtl/haar_addr_gen_if.sv | 46 ++++
 rtl/haar_addr_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/haar_addr_gen_if.sv
// Handshake bundle for haar_addr_gen: feature descriptor in, corner-address stream out.
// master = descriptor producer / address consumer, slave = the generator.
interface haar_addr_gen_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int COORD_W    = 5,
  parameter int MAX_RECT   = 3,
  parameter int WEIGHT_W   = 4
);
  localparam int RN_W  = $clog2(MAX_RECT + 1);
  localparam int IDX_W = (MAX_RECT > 1) ? $clog2(MAX_RECT) : 1;

  logic                           feat_valid_i;
  logic                           feat_ready_o;
  logic [RN_W-1:0]                rect_num_i;
  logic [MAX_RECT*COORD_W-1:0]    rect_x_i;
  logic [MAX_RECT*COORD_W-1:0]    rect_y_i;
  logic [MAX_RECT*COORD_W-1:0]    rect_w_i;
  logic [MAX_RECT*COORD_W-1:0]    rect_h_i;
  logic [MAX_RECT*WEIGHT_W-1:0]   weight_i;
  logic [ADDR_WIDTH-1:0]          win_base_i;

  logic                           addr_valid_o;
  logic                           addr_ready_i;
  logic [ADDR_WIDTH-1:0]          addr_o;
  logic                           sign_o;
  logic [WEIGHT_W-1:0]            weight_o;
  logic [IDX_W-1:0]               rect_idx_o;
  logic [1:0]                     corner_o;
  logic                           last_o;
  logic                           range_err_o;
  logic                           cfg_err_o;

  modport master (
    output feat_valid_i, rect_num_i, rect_x_i, rect_y_i, rect_w_i, rect_h_i,
           weight_i, win_base_i, addr_ready_i,
    input  feat_ready_o, addr_valid_o, addr_o, sign_o, weight_o, rect_idx_o,
           corner_o, last_o, range_err_o, cfg_err_o
  );

  modport slave (
    input  feat_valid_i, rect_num_i, rect_x_i, rect_y_i, rect_w_i, rect_h_i,
           weight_i, win_base_i, addr_ready_i,
    output feat_ready_o, addr_valid_o, addr_o, sign_o, weight_o, rect_idx_o,
           corner_o, last_o, range_err_o, cfg_err_o
  );
endinterface

// File: rtl/haar_addr_gen.sv
// Haar-feature integral-image address generator: one descriptor in, four tagged
// corner addresses per rectangle out on a valid/ready stream.
module haar_addr_gen #(
  parameter int ADDR_WIDTH = 30,
  parameter int LINE_LEN   = 21,
  parameter int WIN_SIZE   = 20,
  parameter int COORD_W    = 5,
  parameter int MAX_RECT   = 3,
  parameter int WEIGHT_W   = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  haar_addr_gen_if.slave  bus
);
  localparam int RN_W  = $clog2(MAX_RECT + 1);
  localparam int IDX_W = (MAX_RECT > 1) ? $clog2(MAX_RECT) : 1;

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;
  state_t state;

  logic [RN_W-1:0]                          rnum_q;
  logic [MAX_RECT-1:0][COORD_W-1:0]         x_q, y_q, w_q, h_q;
  logic [MAX_RECT-1:0][WEIGHT_W-1:0]        wt_q;
  logic [ADDR_WIDTH-1:0]                    base_q;

  logic [MAX_RECT-1:0][ADDR_WIDTH-1:0]      rb0_c, rb1_c, rb0_q, rb1_q;
  logic [MAX_RECT-1:0][COORD_W:0]           xe_c, xe_q;
  logic [MAX_RECT-1:0]                      err_c, err_q;

  logic [IDX_W-1:0]                         ridx_q, nr;
  logic [1:0]                               cor_q, nc;
  logic                                     nlast;

  logic                                     valid_q, sign_q, last_q, rerr_q, cfg_err_q;
  logic [ADDR_WIDTH-1:0]                    addr_q;
  logic [WEIGHT_W-1:0]                      wt_o_q;

  function automatic logic bad_num(input logic [RN_W-1:0] rn);
    return (rn == '0) || (32'(rn) > 32'(MAX_RECT));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] pt_addr(
    input logic [ADDR_WIDTH-1:0] r0, r1,
    input logic [COORD_W-1:0]    x,
    input logic [COORD_W:0]      xe,
    input logic [1:0]            c
  );
    return (c[1] ? r1 : r0) + (c[0] ? ADDR_WIDTH'(xe) : ADDR_WIDTH'(x));
  endfunction

  // Per-rectangle row bases, column end and window check, from the latched descriptor.
  for (genvar k = 0; k < MAX_RECT; k++) begin : g_rect
    logic [COORD_W:0] ye;
    assign xe_c[k]  = {1'b0, x_q[k]} + {1'b0, w_q[k]};
    assign ye       = {1'b0, y_q[k]} + {1'b0, h_q[k]};
    assign rb0_c[k] = base_q + ADDR_WIDTH'(LINE_LEN) * ADDR_WIDTH'(y_q[k]);
    assign rb1_c[k] = base_q + ADDR_WIDTH'(LINE_LEN) * ADDR_WIDTH'(ye);
    assign err_c[k] = (32'(xe_c[k]) > 32'(WIN_SIZE)) || (32'(ye) > 32'(WIN_SIZE));
  end

  always_comb begin
    nc    = cor_q + 2'd1;
    nr    = (cor_q == 2'd3) ? ridx_q + IDX_W'(1) : ridx_q;
    nlast = (nc == 2'd3) && (32'(nr) == 32'(rnum_q) - 32'd1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      rnum_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      wt_q      <= '0;
      base_q    <= '0;
      rb0_q     <= '0;
      rb1_q     <= '0;
      xe_q      <= '0;
      err_q     <= '0;
      ridx_q    <= '0;
      cor_q     <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      sign_q    <= 1'b0;
      wt_o_q    <= '0;
      rerr_q    <= 1'b0;
      last_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state)
        IDLE: if (bus.feat_valid_i) begin
          rnum_q    <= bus.rect_num_i;
          x_q       <= bus.rect_x_i;
          y_q       <= bus.rect_y_i;
          w_q       <= bus.rect_w_i;
          h_q       <= bus.rect_h_i;
          wt_q      <= bus.weight_i;
          base_q    <= bus.win_base_i;
          cfg_err_q <= bad_num(bus.rect_num_i);
          state     <= CALC;
        end
        CALC: if (bad_num(rnum_q)) begin
          state <= IDLE;
        end else begin
          rb0_q   <= rb0_c;
          rb1_q   <= rb1_c;
          xe_q    <= xe_c;
          err_q   <= err_c;
          ridx_q  <= '0;
          cor_q   <= 2'd0;
          valid_q <= 1'b1;
          addr_q  <= pt_addr(rb0_c[0], rb1_c[0], x_q[0], xe_c[0], 2'd0);
          sign_q  <= 1'b0;
          wt_o_q  <= wt_q[0];
          rerr_q  <= err_c[0];
          last_q  <= 1'b0;
          state   <= EMIT;
        end
        EMIT: if (valid_q && bus.addr_ready_i) begin
          if (last_q) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end else begin
            ridx_q <= nr;
            cor_q  <= nc;
            addr_q <= pt_addr(rb0_q[nr], rb1_q[nr], x_q[nr], xe_q[nr], nc);
            sign_q <= nc[0] ^ nc[1];
            wt_o_q <= wt_q[nr];
            rerr_q <= err_q[nr];
            last_q <= nlast;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated with reset so ready is low while held in reset and high in the first cycle after.
  assign bus.feat_ready_o = (state == IDLE) && rst_n_i;
  assign bus.addr_valid_o = valid_q;
  assign bus.addr_o       = addr_q;
  assign bus.sign_o       = sign_q;
  assign bus.weight_o     = wt_o_q;
  assign bus.rect_idx_o   = ridx_q;
  assign bus.corner_o     = cor_q;
  assign bus.last_o       = last_q;
  assign bus.range_err_o  = rerr_q;
  assign bus.cfg_err_o    = cfg_err_q;
endmodule
